// File: rtl/lsu_mem_stage.sv
// rtl/lsu_mem_stage.sv - memory-stage load/store unit with req/ack data port, lane steering and load extend
// Optional misaligned-access trap: define MISALIGN_TRAP_EN.
module lsu_mem_stage #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              mem_write,
    input  logic [1:0]        store_sz,
    input  logic [2:0]        load_sz,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall_o,
    output logic              resp_valid,
    output logic [31:0]       rdata_o,
    output logic              misalign_o,
    output logic              bus_err_o,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [3:0]        dmem_be,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [2:0]        load_sz_q;
    logic [1:0]        lane_q;
    logic              mis_q;
    logic              bus_err_q;
    logic [31:0]       rdata_q;

    logic              accept;
    logic              misaligned;
    logic              timeout;
    logic              timeout_hit;
    logic              ack_taken;
    logic [3:0]        be_c;
    logic [31:0]       wdata_c;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [31:0]       load_ext;

    assign accept      = (state == IDLE) && req_valid;
    assign ack_taken   = ((state == REQ) || (state == WAIT)) && dmem_ack;
    assign timeout     = (MAX_WAIT != 0) && (wait_cnt == CNT_W'(MAX_WAIT - 1));
    assign timeout_hit = (state == WAIT) && !dmem_ack && timeout;

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        if (mem_write) begin
            case (store_sz)
                2'b00:   misaligned = 1'b0;
                2'b01:   misaligned = addr[0];
                default: misaligned = |addr[1:0];
            endcase
        end else begin
            case (load_sz)
                3'b000, 3'b011: misaligned = 1'b0;
                3'b001, 3'b100: misaligned = addr[0];
                default:        misaligned = |addr[1:0];
            endcase
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    // Loads use the same lane mask as the equivalent store width.
    always_comb begin
        be_c    = 4'b1111;
        wdata_c = wdata;
        if (mem_write) begin
            case (store_sz)
                2'b00: begin
                    be_c    = 4'b0001 << addr[1:0];
                    wdata_c = {4{wdata[7:0]}};
                end
                2'b01: begin
                    be_c    = 4'b0011 << {addr[1], 1'b0};
                    wdata_c = {2{wdata[15:0]}};
                end
                default: be_c = 4'b1111;
            endcase
        end else begin
            case (load_sz)
                3'b000, 3'b011: be_c = 4'b0001 << addr[1:0];
                3'b001, 3'b100: be_c = 4'b0011 << {addr[1], 1'b0};
                default:        be_c = 4'b1111;
            endcase
        end
    end

    always_comb begin
        byte_sel = dmem_rdata[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (load_sz_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b011:  load_ext = {24'h0, byte_sel};
            3'b100:  load_ext = {16'h0, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        stall_o    = 1'b0;
        dmem_req   = 1'b0;
        resp_valid = 1'b0;
        misalign_o = 1'b0;
        case (state)
            IDLE: begin
                stall_o = req_valid;
                if (req_valid) begin
                    next_state = misaligned ? RESP : REQ;
                end
            end
            REQ: begin
                stall_o    = 1'b1;
                dmem_req   = 1'b1;
                next_state = dmem_ack ? RESP : WAIT;
            end
            WAIT: begin
                stall_o  = 1'b1;
                dmem_req = 1'b1;
                // An ack on the final allowed cycle wins over the timeout.
                if (dmem_ack) begin
                    next_state = RESP;
                end else if (timeout) begin
                    next_state = IDLE;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                misalign_o = mis_q;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_be    <= 4'b0000;
            dmem_wdata <= 32'h0;
            load_sz_q  <= 3'b000;
            lane_q     <= 2'b00;
            mis_q      <= 1'b0;
            wait_cnt   <= '0;
            bus_err_q  <= 1'b0;
            rdata_q    <= 32'h0;
        end else begin
            bus_err_q <= timeout_hit;
            if (accept) begin
                mis_q    <= misaligned;
                wait_cnt <= '0;
                if (!misaligned) begin
                    dmem_we    <= mem_write;
                    dmem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                    dmem_be    <= be_c;
                    dmem_wdata <= wdata_c;
                    load_sz_q  <= load_sz;
                    lane_q     <= addr[1:0];
                end
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (ack_taken && !dmem_we) begin
                rdata_q <= load_ext;
            end
        end
    end

    assign bus_err_o = bus_err_q;
    assign rdata_o   = rdata_q;

endmodule
